// File: rtl/cram_async_ctrl.sv
// cram_async_ctrl: single-requester sequencer for one cellular RAM port (async, A/D-muxed mode).
// Latency: accept -> o_rsp_valid = ADDR_CYCLES+ACCESS_CYCLES+1; accept-to-accept adds RECOVER_CYCLES.
// Backpressure: o_req_ready is high only in IDLE; requests are never queued.
// Optional build macro: CRAM_CTRL_WAIT_EN (stretch ACCESS while the device holds WAIT).
module cram_async_ctrl #(
  parameter int ADDR_CYCLES    = 2,
  parameter int ACCESS_CYCLES  = 5,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  // request / response side
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [22:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  input  logic [1:0]  i_req_be,
  output logic [15:0] o_rsp_rdata,
  output logic        o_rsp_valid,
  // device side
  output logic [5:0]  o_cram_a,
  output logic [15:0] o_cram_dq_out,
  input  logic [15:0] i_cram_dq_in,
  output logic        o_cram_clk,
  input  logic        i_cram_wait,
  output logic        o_cram_adv_n,
  output logic        o_cram_cre,
  output logic        o_cram_ce0_n,
  output logic        o_cram_ce1_n,
  output logic        o_cram_oe_n,
  output logic        o_cram_we_n,
  output logic        o_cram_ub_n,
  output logic        o_cram_lb_n
);

  // Counter is wide enough for the longest phase.
  localparam int MAX_A  = (ADDR_CYCLES > ACCESS_CYCLES) ? ADDR_CYCLES : ACCESS_CYCLES;
  localparam int MAX_C  = (MAX_A > RECOVER_CYCLES) ? MAX_A : RECOVER_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  // Each phase loads (length-1) and leaves when the counter reaches zero.
  localparam logic [CW-1:0] ADDR_LOAD    = CW'(ADDR_CYCLES - 1);
  localparam logic [CW-1:0] ACCESS_LOAD  = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADDR    = 2'd1,
    S_ACCESS  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;

  // Latched request fields needed after the address phase.
  logic           r_we;
  logic [15:0]    r_wdata;

  // Registered outputs.
  logic           r_req_ready;
  logic           r_rsp_valid;
  logic [15:0]    r_rsp_rdata;
  logic [5:0]     r_cram_a;
  logic [15:0]    r_cram_dq_out;
  logic           r_cram_adv_n;
  logic           r_cram_ce0_n;
  logic           r_cram_ce1_n;
  logic           r_cram_oe_n;
  logic           r_cram_we_n;
  logic           r_cram_ub_n;
  logic           r_cram_lb_n;

  logic           w_accept;
  logic           w_cnt_zero;
  logic           w_access_done;

  assign w_accept   = i_req_valid && r_req_ready;
  assign w_cnt_zero = (r_cnt == '0);

`ifdef CRAM_CTRL_WAIT_EN
  // After the minimum access time, hold ACCESS while the device asserts WAIT;
  // the read sample lands on the first cycle WAIT is seen low.
  assign w_access_done = w_cnt_zero && !i_cram_wait;
`else
  // WAIT is not monitored in this build; keep the pin visibly consumed.
  logic w_unused_wait;
  assign w_unused_wait = i_cram_wait;
  assign w_access_done = w_cnt_zero;
`endif

  // Sequencer: state, phase counter, latched request and every registered output.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_wdata       <= '0;
      r_req_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_cram_a      <= '0;
      r_cram_dq_out <= '0;
      r_cram_adv_n  <= 1'b1;
      r_cram_ce0_n  <= 1'b1;
      r_cram_ce1_n  <= 1'b1;
      r_cram_oe_n   <= 1'b1;
      r_cram_we_n   <= 1'b1;
      r_cram_ub_n   <= 1'b1;
      r_cram_lb_n   <= 1'b1;
    end else begin
      // rsp_valid is a single-cycle pulse unless re-armed below.
      r_rsp_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state       <= S_ADDR;
            r_cnt         <= ADDR_LOAD;
            r_req_ready   <= 1'b0;
            r_we          <= i_req_we;
            r_wdata       <= i_req_wdata;
            // Address phase: chip select from bit 22, low address on dq.
            r_cram_adv_n  <= 1'b0;
            r_cram_ce0_n  <= i_req_addr[22];
            r_cram_ce1_n  <= ~i_req_addr[22];
            r_cram_a      <= i_req_addr[21:16];
            r_cram_dq_out <= i_req_addr[15:0];
            r_cram_oe_n   <= 1'b1;
            r_cram_we_n   <= 1'b1;
            // Reads always fetch both bytes; writes honour the byte enables.
            r_cram_ub_n   <= i_req_we ? ~i_req_be[1] : 1'b0;
            r_cram_lb_n   <= i_req_we ? ~i_req_be[0] : 1'b0;
          end else begin
            r_req_ready <= 1'b1;
          end
        end

        S_ADDR: begin
          if (w_cnt_zero) begin
            r_state      <= S_ACCESS;
            r_cnt        <= ACCESS_LOAD;
            r_cram_adv_n <= 1'b1;
            if (r_we) begin
              r_cram_we_n   <= 1'b0;
              r_cram_dq_out <= r_wdata;
            end else begin
              // Device drives dq from here; the pad driver is off while oe_n=0.
              r_cram_oe_n <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_ACCESS: begin
          if (w_access_done) begin
            r_state       <= S_RECOVER;
            r_cnt         <= RECOVER_LOAD;
            r_rsp_valid   <= 1'b1;
            if (!r_we) begin
              r_rsp_rdata <= i_cram_dq_in;
            end
            r_cram_ce0_n  <= 1'b1;
            r_cram_ce1_n  <= 1'b1;
            r_cram_oe_n   <= 1'b1;
            r_cram_we_n   <= 1'b1;
            r_cram_ub_n   <= 1'b1;
            r_cram_lb_n   <= 1'b1;
            r_cram_dq_out <= '0;
          end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_RECOVER: begin
          if (w_cnt_zero) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_cram_a      = r_cram_a;
  assign o_cram_dq_out = r_cram_dq_out;
  assign o_cram_adv_n  = r_cram_adv_n;
  assign o_cram_ce0_n  = r_cram_ce0_n;
  assign o_cram_ce1_n  = r_cram_ce1_n;
  assign o_cram_oe_n   = r_cram_oe_n;
  assign o_cram_we_n   = r_cram_we_n;
  assign o_cram_ub_n   = r_cram_ub_n;
  assign o_cram_lb_n   = r_cram_lb_n;

  // Async mode: no device clock, no configuration-register access.
  assign o_cram_clk    = 1'b0;
  assign o_cram_cre    = 1'b0;

endmodule

// File: tb/tb_cram_async_ctrl.sv
// Directed bench for cram_async_ctrl (default build, fixed timing) with a
// behavioural CRAM model: latches the address while adv_n is low, writes
// byte lanes while we_n is low, returns stored data (or 16'hCAFE if untouched).
module tb_cram_async_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [22:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic [15:0] rsp_rdata;
  logic        rsp_valid;
  logic [5:0]  cram_a;
  logic [15:0] cram_dq_out, cram_dq_in;
  logic        cram_clk, cram_wait;
  logic        adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cram_async_ctrl dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_rdata(rsp_rdata), .o_rsp_valid(rsp_valid),
    .o_cram_a(cram_a), .o_cram_dq_out(cram_dq_out), .i_cram_dq_in(cram_dq_in),
    .o_cram_clk(cram_clk), .i_cram_wait(cram_wait),
    .o_cram_adv_n(adv_n), .o_cram_cre(cre), .o_cram_ce0_n(ce0_n), .o_cram_ce1_n(ce1_n),
    .o_cram_oe_n(oe_n), .o_cram_we_n(we_n), .o_cram_ub_n(ub_n), .o_cram_lb_n(lb_n)
  );

  // ---------------- device model ----------------
  logic [22:0]  m_addr = '0;
  logic [15:0]  mem [0:255];
  logic [255:0] m_written = '0;
  logic [7:0]   m_idx;
  logic [15:0]  m_tmp;

  assign m_idx      = {m_addr[22], m_addr[6:0]};
  assign cram_dq_in = !oe_n ? (m_written[m_idx] ? mem[m_idx] : 16'hCAFE) : 16'h0000;

  always @(posedge clk) begin
    if (!adv_n && (ce0_n ^ ce1_n))
      m_addr <= {ce0_n, cram_a, cram_dq_out};
    if (!we_n && (ce0_n ^ ce1_n)) begin
      m_tmp = m_written[m_idx] ? mem[m_idx] : 16'hCAFE;
      if (!ub_n) m_tmp[15:8] = cram_dq_out[15:8];
      if (!lb_n) m_tmp[7:0]  = cram_dq_out[7:0];
      mem[m_idx]       <= m_tmp;
      m_written[m_idx] <= 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] strobes();
    return {adv_n, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n, rsp_valid, req_ready};
  endfunction

  // Read and write strobes, and the two chip enables, are mutually exclusive.
  always @(negedge clk)
    check("exclusive", 32'({!oe_n && !we_n, !ce0_n && !ce1_n}), 32'(2'b00));

  // Waits (bounded) at negedges until req_ready is seen; next posedge accepts.
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready"}, 32'(req_ready), 32'(1'b1));
  endtask

  // One full transaction, checked cycle by cycle (n = cycles after accept).
  task automatic run_txn(input logic we, input logic [22:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input logic [15:0] exp_rd, input string tag);
    logic [8:0]  e;
    logic [15:0] edq;
    bit          act, acc_ph;
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
    wait_ready(tag);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      act    = (n <= 7);
      acc_ph = (n >= 3 && n <= 7);
      e[8] = (n > 2);
      e[7] = !(act && !addr[22]);
      e[6] = !(act && addr[22]);
      e[5] = !(acc_ph && !we);
      e[4] = !(acc_ph && we);
      e[3] = act ? (we ? !be[1] : 1'b0) : 1'b1;
      e[2] = act ? (we ? !be[0] : 1'b0) : 1'b1;
      e[1] = (n == 8);
      e[0] = (n == 9);
      check($sformatf("%s strobes c%0d", tag, n), 32'(strobes()), 32'(e));
      if (n <= 7)
        check($sformatf("%s a c%0d", tag, n), 32'(cram_a), 32'(addr[21:16]));
      if (n <= 2 || (we && n <= 7) || n >= 8) begin
        edq = (n <= 2) ? addr[15:0] : (n <= 7) ? wd : 16'h0000;
        check($sformatf("%s dq_out c%0d", tag, n), 32'(cram_dq_out), 32'(edq));
      end
      if (n == 8 && !we)
        check({tag, " rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [22:0] b_addr [0:3];
  logic [15:0] b_data [0:3];
  logic        b_we   [0:3];
  int          acc    [0:3];
  int          n_rv;
  int          k;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; cram_wait = 1'b0;

    // Values held during reset.
    #23;
    check("reset strobes", 32'(strobes()), 32'(9'b1111111_0_0));
    check("reset a/dq", 32'({cram_a, cram_dq_out}), 32'(0));
    check("reset rdata", 32'(rsp_rdata), 32'(0));
    check("reset cre/clk", 32'({cre, cram_clk}), 32'(0));

    @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready low at release", 32'(req_ready), 32'(1'b0));

    // Idle for 100 cycles after release.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("idle strobes %0d", i), 32'(strobes()), 32'(9'b1111111_0_1));
    end
    check("idle a/dq", 32'({cram_a, cram_dq_out}), 32'(0));

    // Basic write, then reads on both chips. WAIT is held high through the
    // chip-1 read; with the wait feature compiled out it must change nothing.
    run_txn(1'b1, 23'h012345, 16'hBEEF, 2'b11, 16'h0000, "wr beef");
    cram_wait = 1'b1;
    run_txn(1'b0, 23'h412345, 16'h0000, 2'b11, 16'hCAFE, "rd cafe");
    cram_wait = 1'b0;
    run_txn(1'b0, 23'h012345, 16'h0000, 2'b00, 16'hBEEF, "rd beef");

    // Back-to-back with req_valid held: accepts exactly 9 cycles apart.
    b_we[0] = 1'b1; b_addr[0] = 23'h000100; b_data[0] = 16'hAAAA;
    b_we[1] = 1'b0; b_addr[1] = 23'h000100; b_data[1] = 16'hAAAA;
    b_we[2] = 1'b1; b_addr[2] = 23'h400101; b_data[2] = 16'h5555;
    b_we[3] = 1'b0; b_addr[3] = 23'h400101; b_data[3] = 16'h5555;
    n_rv = 0;
    req_valid = 1'b1; req_be = 2'b11;
    req_we = b_we[0]; req_addr = b_addr[0]; req_wdata = b_data[0];
    for (int r = 0; r < 4; r++) begin
      k = 0;
      while (!req_ready && k < 40) begin
        if (rsp_valid) begin
          n_rv++;
          if (!b_we[r-1])
            check($sformatf("b2b rdata %0d", r - 1), 32'(rsp_rdata), 32'(b_data[r-1]));
        end
        @(negedge clk);
        k++;
      end
      check($sformatf("b2b ready %0d", r), 32'(req_ready), 32'(1'b1));
      acc[r] = cyc + 1;
      if (r > 0)
        check($sformatf("b2b spacing %0d", r), 32'(acc[r] - acc[r-1]), 32'(9));
      @(negedge clk);
      if (r < 3) begin
        req_we = b_we[r+1]; req_addr = b_addr[r+1]; req_wdata = b_data[r+1];
      end else begin
        req_valid = 1'b0;
      end
    end
    check("b2b rsp count", 32'(n_rv), 32'(3));
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b last rsp", 32'(rsp_valid), 32'(1'b1));
    check("b2b rdata 3", 32'(rsp_rdata), 32'(16'h5555));
    wait_ready("b2b drain");

    // Byte enables: upper byte only, then no bytes at all.
    run_txn(1'b1, 23'h012345, 16'h1234, 2'b10, 16'h0000, "wr ub");
    run_txn(1'b0, 23'h012345, 16'h0000, 2'b00, 16'h12EF, "rd ub");
    run_txn(1'b1, 23'h400101, 16'h0000, 2'b00, 16'h0000, "wr be0");
    run_txn(1'b0, 23'h400101, 16'h0000, 2'b00, 16'h5555, "rd be0");

    // Reset in the third ACCESS cycle of a write aborts it at once.
    req_we = 1'b1; req_addr = 23'h000120; req_wdata = 16'h1111; req_be = 2'b11;
    req_valid = 1'b1;
    wait_ready("abort");
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
    end
    check("abort pre strobes", 32'(strobes()), 32'(9'b1011000_0_0));
    reset_n = 1'b0;
    #1 check("abort strobes", 32'(strobes()), 32'(9'b1111111_0_0));
    check("abort dq_out", 32'(cram_dq_out), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort held %0d", i), 32'(strobes()), 32'(9'b1111111_0_0));
    end
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("abort after %0d", i), 32'(strobes()), 32'(9'b1111111_0_1));
    end
    run_txn(1'b0, 23'h012345, 16'h0000, 2'b00, 16'h12EF, "rd after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
